axi_sram_slave: RTL and testbench

- AXI4 slave endpoint holding a synchronous 64-bit-wide SRAM array; sits directly downstream of the axi_if bus.
- Serves as the memory model / on-chip RAM that the NPC fetch and LSU masters talk to.
- Independent read and write channel FSMs, so one read burst and one write burst can be in flight concurrently.
- Supports INCR and FIXED bursts up to 256 beats, narrow sizes, byte strobes and error responses.

---
 rtl/axi_sram_slave.sv | 276 +++++++++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_slave.sv
// AXI4 slave in front of a synchronous 64-bit SRAM array.
// Read and write channels run independent FSMs so one burst of each can overlap.
module axi_sram_slave #(
    parameter logic [31:0] BASE  = 32'h8000_0000,
    parameter int          DEPTH = 4096,
    parameter int          AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rstn,
    // AW channel
    input  logic [3:0]  s_awid_i,
    input  logic [31:0] s_awaddr_i,
    input  logic [7:0]  s_awlen_i,
    input  logic [2:0]  s_awsize_i,
    input  logic [1:0]  s_awburst_i,
    input  logic        s_awvalid_i,
    output logic        s_awready_o,
    // W channel
    input  logic [63:0] s_wdata_i,
    input  logic [7:0]  s_wstrb_i,
    input  logic        s_wlast_i,
    input  logic        s_wvalid_i,
    output logic        s_wready_o,
    // B channel
    output logic [3:0]  s_bid_o,
    output logic [1:0]  s_bresp_o,
    output logic        s_bvalid_o,
    input  logic        s_bready_i,
    // AR channel
    input  logic [3:0]  s_arid_i,
    input  logic [31:0] s_araddr_i,
    input  logic [7:0]  s_arlen_i,
    input  logic [2:0]  s_arsize_i,
    input  logic [1:0]  s_arburst_i,
    input  logic        s_arvalid_i,
    output logic        s_arready_o,
    // R channel
    output logic [3:0]  s_rid_o,
    output logic [63:0] s_rdata_o,
    output logic [1:0]  s_rresp_o,
    output logic        s_rlast_o,
    output logic        s_rvalid_o,
    input  logic        s_rready_i
);

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [32:0] SPAN        = 33'(DEPTH) << 3;

    typedef enum logic       {R_IDLE, R_DATA} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

    logic [63:0] mem_q [DEPTH];

    // 33-bit subtraction so addresses below BASE show up as a borrow.
    function automatic logic in_range(input logic [31:0] a);
        logic [32:0] off;
        off = {1'b0, a} - {1'b0, BASE};
        return !off[32] && (off < SPAN);
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
        return AW'((a - BASE) >> 3);
    endfunction

    // WRAP and reserved encodings step like INCR; only FIXED holds the address.
    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [1:0] burst,
                                              input logic [2:0] size);
        return (burst == 2'b00) ? a : a + (32'd1 << size);
    endfunction

    // ---------------- read channel ----------------
    r_state_e    r_state_q, r_state_d;
    logic [31:0] raddr_q, raddr_d;
    logic [7:0]  rlen_q, rlen_d, rcnt_q, rcnt_d;
    logic [2:0]  rsize_q, rsize_d;
    logic [1:0]  rburst_q, rburst_d;
    logic [3:0]  rid_q, rid_d;
    logic        rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [63:0] rdata_q;
    logic        r_load;

    always_comb begin
        r_state_d = r_state_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rsize_d   = rsize_q;
        rburst_d  = rburst_q;
        rcnt_d    = rcnt_q;
        rid_d     = rid_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rresp_d   = rresp_q;
        r_load    = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (s_arvalid_i) begin
                    r_state_d = R_DATA;
                    raddr_d   = s_araddr_i;
                    rlen_d    = s_arlen_i;
                    rsize_d   = s_arsize_i;
                    rburst_d  = s_arburst_i;
                    rid_d     = s_arid_i;
                    rcnt_d    = 8'd0;
                    rvalid_d  = 1'b1;
                    rlast_d   = (s_arlen_i == 8'd0);
                    r_load    = 1'b1;
                end
            end
            R_DATA: begin
                if (s_rready_i) begin
                    if (rlast_q) begin
                        r_state_d = R_IDLE;
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                    end else begin
                        raddr_d = next_addr(raddr_q, rburst_q, rsize_q);
                        rcnt_d  = rcnt_q + 8'd1;
                        rlast_d = (rcnt_d == rlen_q);
                        r_load  = 1'b1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        if (r_load)
            rresp_d = (!in_range(raddr_d) || rburst_d[1] || rsize_d[2]) ? RESP_SLVERR : RESP_OKAY;
    end

    // The array read happens on the edge that launches a beat, so a write on
    // that same edge is not yet visible to it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state_q <= R_IDLE;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rsize_q   <= '0;
            rburst_q  <= '0;
            rcnt_q    <= '0;
            rid_q     <= '0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= '0;
            rdata_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rsize_q   <= rsize_d;
            rburst_q  <= rburst_d;
            rcnt_q    <= rcnt_d;
            rid_q     <= rid_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rresp_q   <= rresp_d;
            if (r_load)
                rdata_q <= in_range(raddr_d) ? mem_q[word_idx(raddr_d)] : 64'd0;
        end
    end

    // ---------------- write channel ----------------
    w_state_e    w_state_q, w_state_d;
    logic [31:0] waddr_q, waddr_d;
    logic [7:0]  wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic [2:0]  wsize_q, wsize_d;
    logic [1:0]  wburst_q, wburst_d;
    logic [3:0]  bid_q, bid_d;
    logic        werr_q, werr_d;
    logic        wready_q, wready_d, bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        w_we, beat_err;

    always_comb begin
        w_state_d = w_state_q;
        waddr_d   = waddr_q;
        wlen_d    = wlen_q;
        wsize_d   = wsize_q;
        wburst_d  = wburst_q;
        wcnt_d    = wcnt_q;
        bid_d     = bid_q;
        werr_d    = werr_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        w_we      = 1'b0;
        beat_err  = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (s_awvalid_i) begin
                    w_state_d = W_DATA;
                    waddr_d   = s_awaddr_i;
                    wlen_d    = s_awlen_i;
                    wsize_d   = s_awsize_i;
                    wburst_d  = s_awburst_i;
                    bid_d     = s_awid_i;
                    wcnt_d    = 8'd0;
                    werr_d    = s_awburst_i[1] || s_awsize_i[2];
                    wready_d  = 1'b1;
                end
            end
            W_DATA: begin
                if (s_wvalid_i) begin
                    w_we     = in_range(waddr_q);
                    // wlast is only checked, never trusted: the count ends the burst.
                    beat_err = !w_we || (s_wlast_i != (wcnt_q == wlen_q));
                    if (wcnt_q == wlen_q) begin
                        w_state_d = W_RESP;
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        bresp_d   = (werr_q || beat_err) ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        waddr_d = next_addr(waddr_q, wburst_q, wsize_q);
                        wcnt_d  = wcnt_q + 8'd1;
                        werr_d  = werr_q || beat_err;
                    end
                end
            end
            W_RESP: begin
                if (s_bready_i) begin
                    w_state_d = W_IDLE;
                    bvalid_d  = 1'b0;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state_q <= W_IDLE;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wsize_q   <= '0;
            wburst_q  <= '0;
            wcnt_q    <= '0;
            bid_q     <= '0;
            werr_q    <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wsize_q   <= wsize_d;
            wburst_q  <= wburst_d;
            wcnt_q    <= wcnt_d;
            bid_q     <= bid_d;
            werr_q    <= werr_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int i = 0; i < 8; i++)
                if (s_wstrb_i[i]) mem_q[word_idx(waddr_q)][i*8 +: 8] <= s_wdata_i[i*8 +: 8];
        end
    end

    assign s_arready_o = (r_state_q == R_IDLE);
    assign s_awready_o = (w_state_q == W_IDLE);
    assign s_wready_o  = wready_q;
    assign s_bvalid_o  = bvalid_q;
    assign s_bresp_o   = bresp_q;
    assign s_bid_o     = bid_q;
    assign s_rvalid_o  = rvalid_q;
    assign s_rdata_o   = rdata_q;
    assign s_rresp_o   = rresp_q;
    assign s_rlast_o   = rlast_q;
    assign s_rid_o     = rid_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: a word-array memory model predicts every
// R beat and B response, and one compare process checks them each cycle.
module tb_axi_sram_slave;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 4096;

    logic        clk, rstn;
    logic [3:0]  awid, arid, bid, rid;
    logic [31:0] awaddr, araddr;
    logic [7:0]  awlen, arlen, wstrb;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic [63:0] wdata, rdata;

    axi_sram_slave #(.BASE(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn),
        .s_awid_i(awid), .s_awaddr_i(awaddr), .s_awlen_i(awlen), .s_awsize_i(awsize),
        .s_awburst_i(awburst), .s_awvalid_i(awvalid), .s_awready_o(awready),
        .s_wdata_i(wdata), .s_wstrb_i(wstrb), .s_wlast_i(wlast), .s_wvalid_i(wvalid),
        .s_wready_o(wready),
        .s_bid_o(bid), .s_bresp_o(bresp), .s_bvalid_o(bvalid), .s_bready_i(bready),
        .s_arid_i(arid), .s_araddr_i(araddr), .s_arlen_i(arlen), .s_arsize_i(arsize),
        .s_arburst_i(arburst), .s_arvalid_i(arvalid), .s_arready_o(arready),
        .s_rid_o(rid), .s_rdata_o(rdata), .s_rresp_o(rresp), .s_rlast_o(rlast),
        .s_rvalid_o(rvalid), .s_rready_i(rready)
    );

    typedef struct packed { logic [3:0] id; logic [63:0] data; logic [1:0] resp; logic last; } rbeat_t;
    typedef struct packed { logic [3:0] id; logic [1:0] resp; } bexp_t;

    rbeat_t      rq[$];
    bexp_t       bq[$];
    logic [63:0] mdl [DEPTH];
    logic [63:0] w_data [256];
    logic [7:0]  w_strb [256];
    int          n_chk = 0, n_fail = 0;
    logic        chk_en;
    logic [3:0]  rr_pat;
    logic [63:0] last_rdata = '1;
    logic [1:0]  last_rresp = 2'b11, last_bresp = 2'b11;

    initial begin clk = 1'b0; forever #5 clk = ~clk; end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    function automatic logic in_rng(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'(8 * DEPTH));
    endfunction
    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) / 8);
    endfunction
    function automatic logic [31:0] adv(input logic [31:0] a, input logic [1:0] burst, input logic [2:0] size);
        return (burst == 2'b00) ? a : a + (32'd1 << size);
    endfunction

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] a;
        rbeat_t      b;
        logic        hs, v0;
        int          t;
        a = addr;
        for (int k = 0; k <= int'(len); k++) begin
            b.id   = id;
            b.last = (k == int'(len));
            b.data = in_rng(a) ? mdl[widx(a)] : 64'd0;
            b.resp = (!in_rng(a) || burst >= 2'b10 || size > 3'd3) ? 2'b10 : 2'b00;
            rq.push_back(b);
            a = adv(a, burst, size);
        end
        @(posedge clk); #1;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        hs = 1'b0; v0 = 1'b0; t = 0;
        while (!hs && t < 100) begin
            @(negedge clk); hs = arready; v0 = rvalid;
            @(posedge clk); #1; t++;
        end
        arvalid = 1'b0;
        chk("ar_handshake", 64'(hs), 64'd1);
        chk("r_valid_before_hs", 64'(v0), 64'd0);
        chk("r_latency", 64'(rvalid), 64'd1);
        t = 0;
        while (rq.size() != 0 && t < 2000) begin @(posedge clk); t++; end
        chk("r_drain", 64'(rq.size()), 64'd0);
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int lastbeat);
        logic [31:0] a;
        logic        err, hs;
        bexp_t       e;
        int          t;
        a   = addr;
        err = (burst >= 2'b10) || (size > 3'd3);
        for (int k = 0; k <= int'(len); k++) begin
            if (in_rng(a)) begin
                for (int b = 0; b < 8; b++)
                    if (w_strb[k][b]) mdl[widx(a)][b*8 +: 8] = w_data[k][b*8 +: 8];
            end else err = 1'b1;
            if ((k == lastbeat) != (k == int'(len))) err = 1'b1;
            a = adv(a, burst, size);
        end
        e.id = id; e.resp = err ? 2'b10 : 2'b00;
        bq.push_back(e);
        @(posedge clk); #1;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        hs = 1'b0; t = 0;
        while (!hs && t < 100) begin
            @(negedge clk); hs = awready;
            @(posedge clk); #1; t++;
        end
        awvalid = 1'b0;
        chk("aw_handshake", 64'(hs), 64'd1);
        for (int k = 0; k <= int'(len); k++) begin
            wdata = w_data[k]; wstrb = w_strb[k]; wlast = (k == lastbeat); wvalid = 1'b1;
            hs = 1'b0; t = 0;
            while (!hs && t < 100) begin
                @(negedge clk); hs = wready;
                @(posedge clk); #1; t++;
            end
            if (!hs) chk("w_handshake", 64'(hs), 64'd1);
        end
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic wait_b();
        int t;
        t = 0;
        while (bq.size() != 0 && t < 200) begin @(posedge clk); t++; end
        chk("b_drain", 64'(bq.size()), 64'd0);
    endtask

    // rready follows a 4-phase pattern, re-driven after every rising edge.
    initial begin
        int ph;
        ph = 0; rready = 1'b0;
        forever begin
            @(posedge clk); #1;
            rready = rr_pat[ph];
            ph = (ph + 1) % 4;
        end
    end

    // Compare process: every R beat / B response against the model queues.
    initial begin
        logic bub;
        bub = 1'b0;
        forever begin
            @(negedge clk);
            if (!chk_en || !rstn) begin bub = 1'b0; continue; end
            if (bub) begin
                chk("r_bubble_arready", 64'(arready), 64'd1);
                chk("r_bubble_rvalid", 64'(rvalid), 64'd0);
                bub = 1'b0;
            end
            if (rvalid) begin
                if (rq.size() == 0) chk("r_unexpected", 64'(rvalid), 64'd0);
                else begin
                    chk("rdata", rdata, rq[0].data);
                    chk("rresp", 64'(rresp), 64'(rq[0].resp));
                    chk("rlast", 64'(rlast), 64'(rq[0].last));
                    chk("rid", 64'(rid), 64'(rq[0].id));
                    if (rready) begin
                        last_rdata = rdata; last_rresp = rresp;
                        if (rq[0].last) bub = 1'b1;
                        rq.delete(0);
                    end
                end
            end
            if (bvalid) begin
                if (bq.size() == 0) chk("b_unexpected", 64'(bvalid), 64'd0);
                else begin
                    chk("bid", 64'(bid), 64'(bq[0].id));
                    chk("bresp", 64'(bresp), 64'(bq[0].resp));
                    if (bready) begin last_bresp = bresp; bq.delete(0); end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time limit, expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b1;
        chk_en = 1'b1; rr_pat = 4'b1111; rstn = 1'b1;
        #2 rstn = 1'b0;
        #3;
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_rlast", 64'(rlast), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_rresp", 64'(rresp), 64'd0);
        chk("rst_rid", 64'(rid), 64'd0);
        chk("rst_bvalid", 64'(bvalid), 64'd0);
        chk("rst_bresp", 64'(bresp), 64'd0);
        chk("rst_bid", 64'(bid), 64'd0);
        chk("rst_wready", 64'(wready), 64'd0);
        chk("rst_arready", 64'(arready), 64'd1);
        chk("rst_awready", 64'(awready), 64'd1);
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        // single write then read
        w_data[0] = 64'h1122_3344_5566_7788; w_strb[0] = 8'hFF;
        do_write(4'd3, 32'h8000_0010, 8'd0, 3'd3, 2'b01, 0);
        wait_b();
        chk("t1_bresp", 64'(last_bresp), 64'd0);
        do_read(4'd4, 32'h8000_0010, 8'd0, 3'd3, 2'b01);
        chk("t1_rdata", last_rdata, 64'h1122_3344_5566_7788);

        // INCR 4-beat burst
        for (int k = 0; k < 4; k++) begin w_data[k] = 64'hC0DE_0000_0000_0100 + 64'(k); w_strb[k] = 8'hFF; end
        do_write(4'd1, 32'h8000_0100, 8'd3, 3'd3, 2'b01, 3);
        wait_b();
        do_read(4'd2, 32'h8000_0100, 8'd3, 3'd3, 2'b01);
        chk("t2_last_rdata", last_rdata, 64'hC0DE_0000_0000_0103);

        // byte strobes on a FIXED burst over an all-ones word
        w_data[0] = '1; w_strb[0] = 8'hFF;
        do_write(4'd6, 32'h8000_0200, 8'd0, 3'd3, 2'b01, 0);
        wait_b();
        w_data[0] = 64'd0;                 w_strb[0] = 8'h0F;
        w_data[1] = 64'hABAB_ABAB_ABAB_ABAB; w_strb[1] = 8'hF0;
        do_write(4'd6, 32'h8000_0200, 8'd1, 3'd3, 2'b00, 1);
        wait_b();
        do_read(4'd7, 32'h8000_0200, 8'd0, 3'd3, 2'b01);
        chk("t3_fixed_strb", last_rdata, 64'hABAB_ABAB_0000_0000);

        // R backpressure, then B held off for 5 cycles
        rr_pat = 4'b1001;
        do_read(4'd8, 32'h8000_0100, 8'd3, 3'd3, 2'b01);
        rr_pat = 4'b1111;
        chk("t4_last_rdata", last_rdata, 64'hC0DE_0000_0000_0103);
        bready = 1'b0;
        w_data[0] = 64'h5555_6666_7777_8888; w_strb[0] = 8'hFF;
        do_write(4'd2, 32'h8000_0300, 8'd0, 3'd3, 2'b01, 0);
        begin
            int t;
            t = 0;
            while (!bvalid && t < 20) begin @(posedge clk); #1; t++; end
        end
        for (int c = 0; c < 5; c++) begin @(negedge clk); chk("b_hold", 64'(bvalid), 64'd1); end
        @(posedge clk); #1 bready = 1'b1;
        wait_b();

        // error cases and the top-of-array boundary
        do_read(4'd1, 32'h0000_0000, 8'd0, 3'd3, 2'b01);
        chk("t5_oor_rresp", 64'(last_rresp), 64'd2);
        chk("t5_oor_rdata", last_rdata, 64'd0);
        for (int k = 0; k < 4; k++) begin w_data[k] = 64'h1000 + 64'(k); w_strb[k] = 8'hFF; end
        do_write(4'd3, 32'h8000_0500, 8'd3, 3'd3, 2'b01, 1);
        wait_b();
        chk("t5_wlast_bresp", 64'(last_bresp), 64'd2);
        do_read(4'd3, 32'h8000_0500, 8'd3, 3'd3, 2'b01);
        do_read(4'd5, 32'h8000_0100, 8'd1, 3'd3, 2'b10);
        chk("t5_wrap_rresp", 64'(last_rresp), 64'd2);
        do_read(4'd5, 32'h8000_0100, 8'd0, 3'd4, 2'b01);
        do_read(4'd6, 32'h8000_0100, 8'd3, 3'd2, 2'b01);
        w_data[0] = 64'hFEED_FACE_DEAD_BEEF; w_strb[0] = 8'hFF;
        do_write(4'd4, 32'h8000_7FF8, 8'd0, 3'd3, 2'b01, 0);
        wait_b();
        do_read(4'd6, 32'h8000_7FF8, 8'd1, 3'd3, 2'b01);
        chk("t5_edge_rresp", 64'(last_rresp), 64'd2);

        // overlapping read and write bursts
        for (int k = 0; k < 4; k++) begin w_data[k] = 64'h7700 + 64'(k); w_strb[k] = 8'hFF; end
        fork
            do_write(4'd5, 32'h8000_0400, 8'd3, 3'd3, 2'b01, 3);
            do_read(4'd9, 32'h8000_0100, 8'd3, 3'd3, 2'b01);
        join
        wait_b();
        do_read(4'd10, 32'h8000_0400, 8'd3, 3'd3, 2'b01);
        chk("t6_wr_data", last_rdata, 64'h7703);

        // reset in the middle of both bursts
        chk_en = 1'b0;
        @(posedge clk); #1;
        arid = 4'd1; araddr = 32'h8000_0100; arlen = 8'd7; arsize = 3'd3; arburst = 2'b01; arvalid = 1'b1;
        awid = 4'd2; awaddr = 32'h8000_0600; awlen = 8'd7; awsize = 3'd3; awburst = 2'b01; awvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0; awvalid = 1'b0;
        wvalid = 1'b1; wdata = 64'h9999; wstrb = 8'hFF; wlast = 1'b0;
        @(posedge clk); #1;
        chk("mid_rvalid", 64'(rvalid), 64'd1);
        chk("mid_wready", 64'(wready), 64'd1);
        #2 rstn = 1'b0;
        #1;
        chk("rst_mid_rvalid", 64'(rvalid), 64'd0);
        chk("rst_mid_bvalid", 64'(bvalid), 64'd0);
        chk("rst_mid_wready", 64'(wready), 64'd0);
        wvalid = 1'b0;
        @(posedge clk); #1 rstn = 1'b1;
        #1;
        chk("post_rst_arready", 64'(arready), 64'd1);
        chk("post_rst_awready", 64'(awready), 64'd1);
        @(posedge clk);
        chk_en = 1'b1;
        do_read(4'd11, 32'h8000_0010, 8'd0, 3'd3, 2'b01);
        chk("t7_after_rst", last_rdata, 64'h1122_3344_5566_7788);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
